fetch_unit: RTL and testbench

//  Instruction fetch stage between the program counter and the decoder.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and the opcode bit that
// marks a two-word (immediate-carrying) instruction.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_OP   = 2'd1,
        FETCH_IMM  = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;

    localparam int IMM_BIT = 9;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: reads one/two-word instructions over req/ack, pulses pc_inc per word.
// Zero-wait latency start->valid is 2 cycles (3 for two-word); decode stalls hold {ir,imm} in HOLD.
module fetch_unit #(
    parameter int W       = 16,
    parameter int IMM_BIT = cpu_pkg::IMM_BIT
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic [W-1:0] pc_addr,
    output logic         pc_inc,
    input  logic         redirect,
    output logic         mem_req,
    output logic [W-1:0] mem_addr,
    input  logic [W-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic [W-1:0] ir,
    output logic [W-1:0] imm,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic         busy
);
    import cpu_pkg::*;

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         ir_en;
    logic         imm_en;
    logic         imm_clr;
    logic         addr_en;

    assign mem_req     = (state == FETCH_OP) || (state == FETCH_IMM);
    assign instr_valid = (state == FETCH_HOLD);
    assign busy        = (state != FETCH_IDLE);
    // A redirect discards the acked word, so the PC must not advance past it.
    assign pc_inc      = mem_req & mem_ack & ~redirect;

    always_comb begin
        state_nxt = state;
        ir_en     = 1'b0;
        imm_en    = 1'b0;
        imm_clr   = 1'b0;
        addr_en   = 1'b0;
        if (redirect && (state != FETCH_IDLE)) begin
            addr_en   = 1'b1;
            state_nxt = FETCH_OP;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (start) begin
                        addr_en   = 1'b1;
                        state_nxt = FETCH_OP;
                    end
                end
                FETCH_OP: begin
                    if (mem_ack) begin
                        ir_en = 1'b1;
                        if (mem_rdata[IMM_BIT]) begin
                            // pc_addr already reflects this cycle's increment.
                            addr_en   = 1'b1;
                            state_nxt = FETCH_IMM;
                        end else begin
                            imm_clr   = 1'b1;
                            state_nxt = FETCH_HOLD;
                        end
                    end
                end
                FETCH_IMM: begin
                    if (mem_ack) begin
                        imm_en    = 1'b1;
                        state_nxt = FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (instr_ready) begin
                        addr_en   = 1'b1;
                        state_nxt = FETCH_OP;
                    end
                end
                default: state_nxt = FETCH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state    <= FETCH_IDLE;
            ir       <= '0;
            imm      <= '0;
            mem_addr <= '0;
        end else begin
            state <= state_nxt;
            if (ir_en)
                ir <= mem_rdata;
            if (imm_en)
                imm <= mem_rdata;
            else if (imm_clr)
                imm <= '0;
            if (addr_en)
                mem_addr <= pc_addr;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC model (ld/inc bypass) and an {ir,imm} scoreboard.
module tb_fetch_unit;

    localparam int W = 16;

    logic         clk         = 1'b0;
    logic         rst_b       = 1'b1;
    logic         start       = 1'b0;
    logic         redirect    = 1'b0;
    logic         pc_ld       = 1'b0;
    logic         mem_ack     = 1'b0;
    logic         instr_ready = 1'b0;
    logic [W-1:0] pc_tgt      = '0;
    logic [W-1:0] mem_rdata   = '0;
    logic [W-1:0] pc_reg      = '0;
    logic [W-1:0] pc_addr;

    logic         pc_inc;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic [W-1:0] ir;
    logic [W-1:0] imm;
    logic         instr_valid;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;
    int inc_cnt  = 0;
    int base;
    logic [2*W-1:0] exp_q[$];

    fetch_unit #(.W(W)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (start),
        .pc_addr     (pc_addr),
        .pc_inc      (pc_inc),
        .redirect    (redirect),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .ir          (ir),
        .imm         (imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // PC model: load (redirect or bench preload) wins over increment, both bypassed.
    assign pc_addr = (redirect || pc_ld) ? pc_tgt : pc_reg + {{(W-1){1'b0}}, pc_inc};

    always @(posedge clk) begin
        pc_reg <= pc_addr;
        if (pc_inc)
            inc_cnt <= inc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT requesting; answers after `waits` ack-less cycles.
    task automatic serve(input string tag, input logic [W-1:0] addr, input logic [W-1:0] data,
                         input int waits);
        mem_ack = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1;
            check($sformatf("%s_wait_req", tag), {31'b0, mem_req}, 32'd1);
            check($sformatf("%s_wait_addr", tag), {16'b0, mem_addr}, {16'b0, addr});
            check($sformatf("%s_wait_inc", tag), {31'b0, pc_inc}, 32'd0);
            tick();
        end
        check($sformatf("%s_req", tag), {31'b0, mem_req}, 32'd1);
        check($sformatf("%s_addr", tag), {16'b0, mem_addr}, {16'b0, addr});
        mem_ack   = 1'b1;
        mem_rdata = data;
        #1;
        check($sformatf("%s_inc", tag), {31'b0, pc_inc}, 32'd1);
        tick();
        mem_ack = 1'b0;
    endtask

    // Called at a negedge in HOLD; compares against the scoreboard and accepts.
    task automatic accept(input string tag);
        logic [2*W-1:0] e;
        check($sformatf("%s_valid", tag), {31'b0, instr_valid}, 32'd1);
        check($sformatf("%s_sb_nonempty", tag), {31'b0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s_ir", tag), {16'b0, ir}, {16'b0, e[2*W-1:W]});
            check($sformatf("%s_imm", tag), {16'b0, imm}, {16'b0, e[W-1:0]});
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ir", {16'b0, ir}, 32'd0);
        check("rst_imm", {16'b0, imm}, 32'd0);
        check("rst_addr", {16'b0, mem_addr}, 32'd0);
        rst_b = 1'b0;
        tick();

        // One-word fetch, latency 2 from start
        base   = inc_cnt;
        pc_ld  = 1'b1;
        pc_tgt = 16'h0010;
        start  = 1'b1;
        tick();
        pc_ld = 1'b0;
        start = 1'b0;
        check("one_busy", {31'b0, busy}, 32'd1);
        check("one_c1_valid", {31'b0, instr_valid}, 32'd0);
        exp_q.push_back({16'h1000, 16'h0000});
        serve("one", 16'h0010, 16'h1000, 0);
        check("one_inc_cnt", inc_cnt - base, 1);
        accept("one");
        check("one_next_addr", {16'b0, mem_addr}, 32'h0011);

        // Redirect while waiting in FETCH_OP moves the fetch to 0x0020
        redirect = 1'b1;
        pc_tgt   = 16'h0020;
        tick();
        redirect = 1'b0;

        // Two-word fetch then 5 cycles of decode backpressure
        base = inc_cnt;
        exp_q.push_back({16'h0200, 16'hBEEF});
        serve("two_op", 16'h0020, 16'h0200, 0);
        check("two_mid_valid", {31'b0, instr_valid}, 32'd0);
        serve("two_imm", 16'h0021, 16'hBEEF, 0);
        check("two_inc_cnt", inc_cnt - base, 2);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'b0, instr_valid}, 32'd1);
            check("bp_req", {31'b0, mem_req}, 32'd0);
            check("bp_ir", {16'b0, ir}, 32'h0200);
            check("bp_imm", {16'b0, imm}, 32'hBEEF);
            tick();
        end
        accept("two");

        // Wait states: 3 ack-less cycles on each word
        exp_q.push_back({16'h0300, 16'h1234});
        serve("ws_op", 16'h0022, 16'h0300, 3);
        serve("ws_imm", 16'h0023, 16'h1234, 3);
        accept("ws");

        // Redirect in FETCH_IMM with a same-cycle ack: word dropped, no pc_inc
        serve("rd_op", 16'h0024, 16'h0200, 0);
        base      = inc_cnt;
        redirect  = 1'b1;
        pc_tgt    = 16'h0400;
        mem_ack   = 1'b1;
        mem_rdata = 16'h5555;
        #1;
        check("rd_inc", {31'b0, pc_inc}, 32'd0);
        tick();
        redirect = 1'b0;
        mem_ack  = 1'b0;
        check("rd_imm_kept", {16'b0, imm}, 32'h1234);
        check("rd_addr", {16'b0, mem_addr}, 32'h0400);
        check("rd_valid", {31'b0, instr_valid}, 32'd0);
        check("rd_inc_cnt", inc_cnt - base, 0);
        exp_q.push_back({16'h0042, 16'h0000});
        serve("tgt", 16'h0400, 16'h0042, 0);
        accept("tgt");

        // Asynchronous reset in the middle of a FETCH_OP request
        check("mid_req_pre", {31'b0, mem_req}, 32'd1);
        #2;
        rst_b = 1'b1;
        #1;
        check("mid_rst_req", {31'b0, mem_req}, 32'd0);
        check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_ir", {16'b0, ir}, 32'd0);
        tick();
        rst_b = 1'b0;
        tick();

        // Address wrap on a two-word instruction at 0xFFFF, latency 3 from start
        pc_ld  = 1'b1;
        pc_tgt = 16'hFFFF;
        start  = 1'b1;
        tick();
        pc_ld = 1'b0;
        start = 1'b0;
        exp_q.push_back({16'h0200, 16'hCAFE});
        serve("wrap_op", 16'hFFFF, 16'h0200, 0);
        serve("wrap_imm", 16'h0000, 16'hCAFE, 0);
        accept("wrap");

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
